// File: rtl/tick_scheduler.sv
// tick_scheduler: base period timer plus round-robin arbiter that hands the
// shared move/draw engine to each requester marked pending by a frame tick.
module tick_scheduler #(
  parameter int N_REQ = 4,
  parameter int INTERVAL_W = 28
) (
  input  logic                  clock_50,
  input  logic                  reset,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  en,
  input  logic [N_REQ-1:0]      req_en,
  input  logic                  done,
  input  logic                  clr_overrun,
  output logic [INTERVAL_W-1:0] cur_time,
  output logic                  frame_tick,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic                  overrun
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_next;
  logic [N_REQ-1:0] pending, clr;
  logic [PW-1:0] ptr, cur_idx, sel;
  logic tick;
  // >= rather than == so a shrinking interval wraps at once instead of rolling over
  assign tick = en && cur_time >= interval;
  assign clr = (state == GRANT && done) ? grant : '0;
  assign busy = |grant || |pending;
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      cur_time <= '0;
      frame_tick <= 1'b0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      cur_time <= tick ? '0 : en ? cur_time + 1'b1 : cur_time;
      frame_tick <= tick;
      pending <= tick ? (pending & ~clr) | req_en : pending & ~clr;
      overrun <= (tick && |(pending & ~clr)) || (overrun && !clr_overrun);
    end
  end
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cur_idx <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) cur_idx <= sel;
      if (state == GRANT && done) ptr <= (cur_idx == PW'(N_REQ - 1)) ? '0 : cur_idx + 1'b1;
    end
  end
  always_comb begin
    state_next = state == IDLE ? (|pending ? GRANT : IDLE) : (done ? IDLE : GRANT);
  end
  // scan downward so the nearest pending bit at or after ptr is the one kept
  always_comb begin
    int j;
    j = 0;
    sel = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= N_REQ ? j - N_REQ : j;
      if (pending[PW'(j)]) sel = PW'(j);
    end
  end
  always_comb begin
    grant = '0;
    grant[cur_idx] = state == GRANT;
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed scenarios plus randomized traffic against a
// behavioural frame/arbitration model.
module tb_tick_scheduler;
  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  logic [27:0] interval = '0;
  logic en = 1'b0;
  logic [3:0] req_en = '0;
  logic done = 1'b0;
  logic clr_overrun = 1'b0;
  logic [27:0] cur_time;
  logic frame_tick;
  logic [3:0] grant;
  logic busy;
  logic overrun;

  tick_scheduler #(.N_REQ(4), .INTERVAL_W(28)) dut (
    .clock_50(clock_50), .reset(reset), .interval(interval), .en(en),
    .req_en(req_en), .done(done), .clr_overrun(clr_overrun),
    .cur_time(cur_time), .frame_tick(frame_tick), .grant(grant),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock_50 = ~clock_50;

  int checks = 0, fails = 0;
  int m_time, m_owner, m_ptr, held, done_lat;
  bit m_tick, m_ovr, done_rnd, prev_zero;
  bit [3:0] m_pend;
  int order[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_tick = 0; m_pend = 0; m_owner = -1; m_ptr = 0; m_ovr = 0; held = 0;
    prev_zero = 1;
  endtask

  task automatic model_edge();
    bit [3:0] clr, np;
    bit tk;
    int nown;
    clr = (m_owner >= 0 && done) ? 4'(1 << m_owner) : 4'd0;
    tk = en && m_time >= int'(interval);
    np = m_pend & ~clr;
    if (tk && np != 0) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    if (tk) np |= req_en;
    nown = m_owner;
    if (m_owner >= 0) begin
      if (done) begin
        m_ptr = (m_owner + 1) % 4;
        nown = -1;
      end
    end else if (m_pend != 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_pend[(m_ptr + k) % 4]) begin
          nown = (m_ptr + k) % 4;
          break;
        end
      end
    end
    held = (nown >= 0 && nown == m_owner) ? held + 1 : 0;
    m_owner = nown;
    m_pend = np;
    m_tick = tk;
    m_time = tk ? 0 : en ? m_time + 1 : m_time;
  endtask

  task automatic step();
    done = done_rnd ? ($urandom_range(0, 2) == 0) : (m_owner >= 0 && held >= done_lat);
    model_edge();
    @(posedge clock_50);
    #1;
    chk("cur_time", 32'(cur_time), 32'(m_time));
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("grant", 32'(grant), m_owner < 0 ? 32'd0 : 32'(1 << m_owner));
    chk("busy", 32'(busy), 32'(m_owner >= 0 || m_pend != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (grant != 0 && prev_zero)
      for (int i = 0; i < 4; i++) if (grant[i]) order.push_back(i);
    prev_zero = grant == 0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_time", 32'(cur_time), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clock_50);
    reset = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 100);
    chk("tick_wait", 32'(frame_tick), 1);
  endtask

  initial begin
    done_rnd = 0;
    done_lat = 1000;
    model_reset();
    do_reset();
    // reset while a grant is held
    interval = 28'd3; en = 1'b1; req_en = 4'b0010;
    for (int n = 0; n < 50 && grant != 4'b0010; n++) step();
    chk("t1_grant_before", 32'(grant), 32'h2);
    do_reset();
    // free-running timer, no requesters
    req_en = 4'b0000; done_lat = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t2_time", 32'(cur_time), 32'((i + 1) % 4));
      chk("t2_tick", 32'(frame_tick), 32'((i + 1) % 4 == 0));
      chk("t2_busy", 32'(busy), 0);
    end
    // three requesters, done two cycles into each grant
    do_reset();
    interval = 28'd19; req_en = 4'b1011; done_lat = 1;
    wait_tick();
    order.delete();
    repeat (17) step();
    chk("t3_busy", 32'(busy), 0);
    chk("t3_overrun", 32'(overrun), 0);
    chk("t3_count", 32'(order.size()), 3);
    chk("t3_o0", 32'(order[0]), 0);
    chk("t3_o1", 32'(order[1]), 1);
    chk("t3_o2", 32'(order[2]), 3);
    // all four, immediate done, two frames
    do_reset();
    req_en = 4'b1111; done_lat = 0;
    wait_tick();
    order.delete();
    repeat (40) step();
    chk("t4_count", 32'(order.size()), 8);
    for (int i = 0; i < 8; i++) chk("t4_order", 32'(order[i]), 32'(i % 4));
    // engine never finishes
    do_reset();
    interval = 28'd3; req_en = 4'b0001; done_lat = 1000;
    wait_tick();
    wait_tick();
    chk("t5_overrun", 32'(overrun), 1);
    chk("t5_grant", 32'(grant), 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t5_cleared", 32'(overrun), 0);
    // interval lowered below the running count, then timer frozen
    do_reset();
    interval = 28'd100; req_en = 4'b0000; done_lat = 0;
    repeat (10) step();
    chk("t6_at10", 32'(cur_time), 10);
    interval = 28'd5;
    step();
    chk("t6_wrap", 32'(cur_time), 0);
    chk("t6_tick", 32'(frame_tick), 1);
    repeat (3) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_frozen", 32'(cur_time), 3);
      chk("t6_notick", 32'(frame_tick), 0);
    end
    // randomized traffic
    en = 1'b1; done_rnd = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) interval = 28'($urandom_range(0, 7));
      en = $urandom_range(0, 7) != 0;
      req_en = 4'($urandom);
      clr_overrun = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
